// File: rtl/uart_deser_gen_if.sv
// Parallel output channel of the deserializer: registered word plus a
// valid/ready handshake. The deserializer drives it through the master modport,
// and the consumer uses the slave modport.
interface uart_deser_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_data;
    logic                  P_valid;
    logic                  P_ready;

    modport master (
        output P_data,
        output P_valid,
        input  P_ready
    );

    modport slave (
        input  P_data,
        input  P_valid,
        output P_ready
    );
endinterface

// File: rtl/uart_deser_gen.sv
// uart_deser_gen: serial-to-parallel deserializer for UART frames.
// Shifts in one sampled bit per deser_en strobe after a frame_start. It
// publishes each completed word on a valid/ready channel and pulses overrun
// when an unconsumed word is overwritten.
// Optional feature: define UART_DESER_PARITY_EN to add parameter PAR_ODD and
// output par_bit, which is the parity of each completed word.
//
// state | meaning
// IDLE  | waiting for frame_start; strobes are ignored
// SHIFT | capturing data bits, one per deser_en cycle
module uart_deser_gen #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
`ifdef UART_DESER_PARITY_EN
    ,
    parameter bit PAR_ODD    = 1'b0
`endif
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     sampled_bit,
    input  logic                     deser_en,
    input  logic                     frame_start,
    uart_deser_gen_if.master         out_if,
    output logic                     overrun,
    output logic                     busy
`ifdef UART_DESER_PARITY_EN
    ,
    output logic                     par_bit
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  take_bit;
    logic                  word_done;
    logic                  handshake;

    assign out_if.P_data  = data_q;
    assign out_if.P_valid = valid_q;
    assign handshake      = valid_q & out_if.P_ready;

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture strobes. If frame_start and deser_en are high
    // together, frame_start wins and the bit is dropped.
    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!frame_start && deser_en) begin
                    take_bit = 1'b1;
                    if (bit_cnt == LAST_IDX) begin
                        word_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register value including the incoming bit. In LSB-first mode,
    // bits enter at the top and march down, so the first bit ends in bit 0.
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], sampled_bit};
        end else begin
            shift_next = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // Bit counter and partial-word storage. Both clear on a new frame and
    // after each completed word.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (frame_start) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (take_bit) begin
            if (word_done) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                shift_reg <= shift_next;
            end
        end
    end

    // Output word, valid flag, and overrun pulse. A completion always wins
    // over a same-cycle handshake, so the new word stays valid.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= word_done & valid_q & ~out_if.P_ready;
            if (word_done) begin
                data_q  <= shift_next;
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
        end
    end

    // busy is registered from the next state, so it tracks state exactly.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
        end
    end

`ifdef UART_DESER_PARITY_EN
    // Parity of the completed word, loaded together with P_data.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            par_bit <= 1'b0;
        end else if (word_done) begin
            par_bit <= (^shift_next) ^ PAR_ODD;
        end
    end
`endif

endmodule

// File: tb/tb_uart_deser_gen.sv
// Testbench for uart_deser_gen. Two instances share one serial stream: one is
// LSB-first and one is MSB-first. Outputs are compared every cycle against a
// frame-level reference model.
module tb_uart_deser_gen;

    localparam int DW = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic sampled_bit = 1'b0;
    logic deser_en = 1'b0;
    logic frame_start = 1'b0;
    logic overrun_l, overrun_m, busy_l, busy_m;
`ifdef UART_DESER_PARITY_EN
    logic par_l, par_m;
`endif

    int checks = 0;
    int errors = 0;

    uart_deser_gen_if #(.DATA_WIDTH(DW)) if_l ();
    uart_deser_gen_if #(.DATA_WIDTH(DW)) if_m ();

    always #5 Clk = ~Clk;

    uart_deser_gen #(
        .DATA_WIDTH(DW), .MSB_FIRST(1'b0)
`ifdef UART_DESER_PARITY_EN
        , .PAR_ODD(1'b0)
`endif
    ) dut_l (
        .Clk(Clk), .Rst(Rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .frame_start(frame_start), .out_if(if_l.master), .overrun(overrun_l), .busy(busy_l)
`ifdef UART_DESER_PARITY_EN
        , .par_bit(par_l)
`endif
    );

    uart_deser_gen #(
        .DATA_WIDTH(DW), .MSB_FIRST(1'b1)
`ifdef UART_DESER_PARITY_EN
        , .PAR_ODD(1'b1)
`endif
    ) dut_m (
        .Clk(Clk), .Rst(Rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .frame_start(frame_start), .out_if(if_m.master), .overrun(overrun_m), .busy(busy_m)
`ifdef UART_DESER_PARITY_EN
        , .par_bit(par_m)
`endif
    );

    // Reference model: this is the state after the most recent clock edge.
    bit          m_active = 0;
    int          m_bits[$];
    logic [DW-1:0] m_data_l = '0, m_data_m = '0;
    bit          m_valid = 0, m_ovr = 0;
    bit          m_par_l = 0, m_par_m = 0;
    int          ovr_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_bits.delete();
        m_data_l = '0;
        m_data_m = '0;
        m_valid = 0;
        m_ovr = 0;
        m_par_l = 0;
        m_par_m = 0;
    endtask

    task automatic model_clock(input bit fs, input bit en, input bit b, input bit rdy);
        bit done = 0;
        bit hs = m_valid && rdy;
        logic [DW-1:0] wl = '0, wm = '0;
        if (fs) begin
            m_active = 1;
            m_bits.delete();
        end else if (m_active && en) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == DW) begin
                for (int i = 0; i < DW; i++) begin
                    wl[i]        = m_bits[i][0];
                    wm[DW-1-i]   = m_bits[i][0];
                end
                done = 1;
                m_active = 0;
                m_bits.delete();
            end
        end
        m_ovr = done && m_valid && !rdy;
        if (done) begin
            m_data_l = wl;
            m_data_m = wm;
            m_valid  = 1;
            m_par_l  = ^wl;
            m_par_m  = ~(^wm);
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("data_lsb", 32'(if_l.P_data), 32'(m_data_l));
        check("data_msb", 32'(if_m.P_data), 32'(m_data_m));
        check("valid_lsb", 32'(if_l.P_valid), 32'(m_valid));
        check("valid_msb", 32'(if_m.P_valid), 32'(m_valid));
        check("overrun_lsb", 32'(overrun_l), 32'(m_ovr));
        check("overrun_msb", 32'(overrun_m), 32'(m_ovr));
        check("busy_lsb", 32'(busy_l), 32'(m_active));
        check("busy_msb", 32'(busy_m), 32'(m_active));
`ifdef UART_DESER_PARITY_EN
        check("par_even", 32'(par_l), 32'(m_par_l));
        check("par_odd", 32'(par_m), 32'(m_par_m));
`endif
    endtask

    // One clock cycle: drive on the falling edge and update the model on the
    // rising edge. Compare just after the rising edge.
    task automatic step(input bit fs, input bit en, input bit b, input bit rdy);
        @(negedge Clk);
        frame_start = fs;
        deser_en    = en;
        sampled_bit = b;
        if_l.P_ready = rdy;
        if_m.P_ready = rdy;
        @(posedge Clk);
        model_clock(fs, en, b, rdy);
        #1;
        if (overrun_l) ovr_seen++;
        compare_all();
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit rdy);
        step(1, 0, 0, rdy);
        for (int i = 0; i < DW; i++) step(0, 1, w[i], rdy);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w;
        if_l.P_ready = 1'b0;
        if_m.P_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge Clk);
        Rst = 1'b1;

        // Known word, including the one-cycle latency to valid.
        w = 8'hA5;
        step(1, 0, 0, 0);
        for (int i = 0; i < DW; i++) begin
            if (i == DW - 1) begin
                @(negedge Clk);
                frame_start = 0; deser_en = 1; sampled_bit = w[i];
                #1 check("valid_before_last_edge", 32'(if_l.P_valid), 32'd0);
                @(posedge Clk);
                model_clock(0, 1, w[i], 0);
                #1 compare_all();
            end else begin
                step(0, 1, w[i], 0);
            end
        end
        check("a5_word", 32'(if_l.P_data), 32'h0000_00A5);
        check("a5_valid", 32'(if_l.P_valid), 32'd1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("valid_cleared", 32'(if_l.P_valid), 32'd0);

        // Bit order: the stream 1,1,0,0,0,0,0,0 gives C0 (MSB-first) or 03.
        send_word(8'h03, 1);
        check("order_lsb", 32'(if_l.P_data), 32'h03);
        check("order_msb", 32'(if_m.P_data), 32'hC0);
        step(0, 0, 0, 1);

        // Two words with no consumer: exactly one overrun, and the last word wins.
        ovr_seen = 0;
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        step(0, 0, 0, 0);
        check("overrun_count", 32'(ovr_seen), 32'd1);
        check("overrun_word", 32'(if_l.P_data), 32'h22);
        check("overrun_valid", 32'(if_l.P_valid), 32'd1);

        // A completion during a handshake: new word, still valid, no overrun.
        step(1, 0, 0, 1);
        for (int i = 0; i < DW; i++) step(0, 1, i[0], 1);

        // Restarting the frame discards the partial bits, and a collision drops the bit.
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        w = 8'h3C;
        for (int i = 0; i < DW; i++) step(0, 1, w[i], 1);
        check("restart_word", 32'(if_l.P_data), 32'h3C);

        // Strobes while idle are ignored.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
        check("idle_busy", 32'(busy_l), 32'd0);

        // Reset in the middle of a frame; a new frame_start is needed afterwards.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        send_word(8'hFF, 0);
        check("post_reset_word", 32'(if_l.P_data), 32'hFF);
        check("post_reset_ovr", 32'(overrun_l), 32'd0);
`ifdef UART_DESER_PARITY_EN
        send_word(8'h07, 1);
        check("par_07_even", 32'(par_l), 32'd1);
`endif

        // Random traffic: frames with gaps, aborts, collisions and a random consumer.
        for (int f = 0; f < 60; f++) begin
            int n;
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(0, DW - 1);
                for (int i = 0; i < n; i++) step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
                step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            end
            n = 0;
            while (n < DW) begin
                bit en = ($urandom_range(0, 3) != 0);
                step(0, en, $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
                if (en) n++;
            end
            for (int i = 0; i < $urandom_range(0, 3); i++)
                step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
